// File: rtl/seq_block_adder_pkg.sv
// Shared definitions for the block-serial adder: FSM states and operation mode encodings.
package seq_block_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_INC = 1'b1;

endpackage

// File: rtl/blk_ripple_adder.sv
// Combinational BLK-bit ripple-carry adder built from full-adder cells.
module blk_ripple_adder #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < BLK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[BLK];

endmodule

// File: rtl/seq_block_adder.sv
// Block-serial adder: one BLK-bit slice of A+B per cycle through a single shared
// ripple adder, with the carry carried between slices in a register.
module seq_block_adder
    import seq_block_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK  = WIDTH / BLK;
    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

    if (((WIDTH % BLK) != 0) || (NBLK < 2)) begin : g_param_err
        $error("seq_block_adder: WIDTH must be a multiple of BLK with at least two blocks");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [BLK-1:0]   w_a_blk;
    logic [BLK-1:0]   w_b_blk;
    logic [BLK-1:0]   w_sum_blk;
    logic             w_cout_blk;

    assign w_a_blk = r_a[r_idx*BLK +: BLK];
    assign w_b_blk = r_b[r_idx*BLK +: BLK];

    blk_ripple_adder #(
        .BLK (BLK)
    ) u_blk_adder (
        .a    (w_a_blk),
        .b    (w_b_blk),
        .cin  (r_carry),
        .sum  (w_sum_blk),
        .cout (w_cout_blk)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= (mode == MODE_INC) ? '0 : b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx*BLK +: BLK] <= w_sum_blk;
                    r_carry                 <= w_cout_blk;
                    r_idx                   <= r_idx + 1'b1;
                    // The top slice's MSB is the result sign bit, so overflow is known here.
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_cout_blk;
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_sum_blk[BLK-1] != r_a[WIDTH-1]);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_block_adder.sv
// Self-checking bench for seq_block_adder: directed corner cases plus random operations
// on a 16/4 instance and an 8/2 instance, checked against an arithmetic reference model.
module tb_seq_block_adder;
    import seq_block_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel8;
    logic        iv;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        mode;

    logic        rdy16, ov16, cout16, ovf16;
    logic [15:0] sum16;
    logic        rdy8, ov8, cout8, ovf8;
    logic [7:0]  sum8;

    logic        o_rdy, o_ov, o_cout, o_ovf;
    logic [15:0] o_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_block_adder #(.WIDTH(16), .BLK(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv & ~sel8),
        .in_ready  (rdy16),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (ov16),
        .out_ready (out_ready),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16)
    );

    seq_block_adder #(.WIDTH(8), .BLK(2)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv & sel8),
        .in_ready  (rdy8),
        .a         (a[7:0]),
        .b         (b[7:0]),
        .cin       (cin),
        .mode      (mode),
        .out_valid (ov8),
        .out_ready (out_ready),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8)
    );

    assign o_rdy  = sel8 ? rdy8  : rdy16;
    assign o_ov   = sel8 ? ov8   : ov16;
    assign o_sum  = sel8 ? {8'h00, sum8} : sum16;
    assign o_cout = sel8 ? cout8 : cout16;
    assign o_ovf  = sel8 ? ovf8  : ovf16;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference result {ovf, cout, sum} for a w-bit operation.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic m, input int w);
        int unsigned mask, xe, ye, full, s;
        logic co, ov;
        mask = (32'd1 << w) - 1;
        xe   = x & mask;
        ye   = (m == MODE_INC) ? 0 : (y & mask);
        full = xe + ye + c;
        s    = full & mask;
        co   = full[w];
        ov   = (xe[w-1] == ye[w-1]) && (s[w-1] != xe[w-1]);
        return {ov, co, s[15:0]};
    endfunction

    task automatic run_op(input logic s8, input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic m, input int hold, input string tag);
        logic [17:0] e;
        int lat;
        e    = model(x, y, c, m, s8 ? 8 : 16);
        sel8 = s8;
        lat  = 0;
        while (!o_rdy && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_in_ready"}, 32'(o_rdy), 32'd1);
        a = x; b = y; cin = c; mode = m; iv = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        iv = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); mode = 1'($urandom);
        lat = 1;
        while (!o_ov && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            iv = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
        end
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        chk({tag, "_sum"}, 32'(o_sum), 32'(e[15:0]));
        chk({tag, "_cout"}, 32'(o_cout), 32'(e[16]));
        chk({tag, "_ovf"}, 32'(o_ovf), 32'(e[17]));
        chk({tag, "_busy"}, 32'(o_rdy), 32'd0);
        for (int i = 0; i < hold; i++) begin
            iv = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(o_ov), 32'd1);
            chk({tag, "_hold_sum"}, {o_ovf, o_cout, 14'd0, o_sum}, {e[17], e[16], 14'd0, e[15:0]});
            chk({tag, "_hold_rdy"}, 32'(o_rdy), 32'd0);
        end
        iv = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(o_ov), 32'd0);
        chk({tag, "_idle_rdy"}, 32'(o_rdy), 32'd1);
        chk({tag, "_kept_sum"}, 32'(o_sum), 32'(e[15:0]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst_n = 1'b0; sel8 = 1'b0; iv = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; mode = MODE_ADD;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy16", 32'(rdy16), 32'd0);
        chk("rst_rdy8", 32'(rdy8), 32'd0);
        chk("rst_valid", 32'({ov16, ov8}), 32'd0);
        chk("rst_sum16", 32'(sum16), 32'd0);
        chk("rst_flags", 32'({cout16, ovf16, cout8, ovf8}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_rdy", 32'({rdy16, rdy8}), 32'd3);

        run_op(1'b0, 16'h1234, 16'h0001, 1'b0, MODE_ADD, 0, "add_basic");
        run_op(1'b0, 16'hFFFF, 16'h5555, 1'b1, MODE_INC, 0, "inc_wrap");
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, MODE_ADD, 0, "add_ovf");
        run_op(1'b0, 16'hABCD, 16'h1111, 1'b0, MODE_ADD, 5, "backpressure");
        run_op(1'b0, 16'h8000, 16'h8000, 1'b0, MODE_ADD, 1, "neg_ovf");

        // Abort an operation two slices in.
        sel8 = 1'b0; a = 16'h1357; b = 16'h2468; cin = 1'b1; mode = MODE_ADD; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort_valid", 32'(ov16), 32'd0);
        chk("abort_sum", 32'(sum16), 32'd0);
        chk("abort_rdy", 32'(rdy16), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_result", 32'(ov16), 32'd0);
        end
        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, MODE_ADD, 0, "after_abort");

        run_op(1'b1, 16'h00AA, 16'h0055, 1'b1, MODE_ADD, 1, "w8_wrap");
        run_op(1'b1, 16'h007F, 16'h0000, 1'b1, MODE_INC, 0, "w8_inc_ovf");
        for (int i = 0; i < 12; i++) begin
            run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), "w8_rand");
        end
        for (int i = 0; i < 25; i++) begin
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), "w16_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
